// File: rtl/bram_pkg.sv
// Shared definitions for the PS/PL mailbox BRAM: geometry defaults, mailbox map,
// arbiter state encoding and the read-tag record carried down the return pipeline.
package bram_pkg;

  localparam int BRAM_AW = 8;
  localparam int BRAM_DW = 32;

  localparam logic [BRAM_AW-1:0] IMG_BASE    = 8'd0;
  localparam logic [BRAM_AW-1:0] FLAG_ADDR   = 8'd196;
  localparam logic [BRAM_AW-1:0] RESULT_ADDR = 8'd197;
  localparam logic [BRAM_DW-1:0] FLAG_READY  = 32'hffff_ffff;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } arb_state_e;

  typedef struct packed {
    logic is_read;
    logic id;
  } rd_tag_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// Two-stage return-tag pipeline: tags each accepted read with its requester so
// the BRAM data, valid two cycles after acceptance, is steered to the issuer.
module rd_tag_pipe
  import bram_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  rd_tag_t tag_i,
  output logic    rvalid0_o,
  output logic    rvalid1_o
);

  rd_tag_t tag_p1_q, tag_p2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_p1_q <= '0;
      tag_p2_q <= '0;
    end else begin
      tag_p1_q <= tag_i;
      tag_p2_q <= tag_p1_q;
    end
  end

  assign rvalid0_o = tag_p2_q.is_read && !tag_p2_q.id;
  assign rvalid1_o = tag_p2_q.is_read &&  tag_p2_q.id;

endmodule

// File: rtl/bram_port_arbiter.sv
// Round-robin, burst-locked arbiter sharing one BRAM port between the image
// loader (0) and the result/status writer (1); registers the BRAM command.
module bram_port_arbiter
  import bram_pkg::*;
#(
  parameter int AW = BRAM_AW,
  parameter int DW = BRAM_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  output logic          gnt0,
  output logic          gnt1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] din0,
  input  logic [DW-1:0] din1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          bram_we,
  output logic [AW-1:0] bram_addr,
  output logic [DW-1:0] bram_din,
  input  logic [DW-1:0] bram_dout
);

  arb_state_e    state_q, state_d;
  logic          last_q, last_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] din_q, din_d;

  logic          acc;
  logic          acc_we;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_din;
  rd_tag_t       acc_tag;

  // Ownership only moves on release; a tie from IDLE goes to the non-last owner.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (req0 && req1)  state_d = last_q ? OWN0 : OWN1;
        else if (req0)     state_d = OWN0;
        else if (req1)     state_d = OWN1;
      end
      OWN0: begin
        if (!req0) begin
          last_d  = 1'b0;
          state_d = req1 ? OWN1 : IDLE;
        end
      end
      OWN1: begin
        if (!req1) begin
          last_d  = 1'b1;
          state_d = req0 ? OWN0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    acc      = 1'b0;
    acc_we   = 1'b0;
    acc_addr = addr0;
    acc_din  = din0;
    if (state_q == OWN0 && req0) begin
      acc    = 1'b1;
      acc_we = we0;
    end else if (state_q == OWN1 && req1) begin
      acc      = 1'b1;
      acc_we   = we1;
      acc_addr = addr1;
      acc_din  = din1;
    end
    acc_tag.is_read = acc && !acc_we;
    acc_tag.id      = (state_q == OWN1);
  end

  // Idle cycles deassert the write enable but leave address and data parked.
  always_comb begin
    we_d   = acc && acc_we;
    addr_d = acc ? acc_addr : addr_q;
    din_d  = acc ? acc_din  : din_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
    end
  end

  rd_tag_pipe u_rd_tag_pipe (
    .clk       (clk),
    .reset     (reset),
    .tag_i     (acc_tag),
    .rvalid0_o (rvalid0),
    .rvalid1_o (rvalid1)
  );

  assign gnt0      = (state_q == OWN0);
  assign gnt1      = (state_q == OWN1);
  assign bram_we   = we_q;
  assign bram_addr = addr_q;
  assign bram_din  = din_q;
  assign rdata0    = bram_dout;
  assign rdata1    = bram_dout;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Scoreboard bench for bram_port_arbiter: two requester agents fed from op queues,
// a behavioural BRAM, a reference arbiter/memory model and a decoupled read monitor.
module tb_bram_port_arbiter;
  import bram_pkg::*;

  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] din0, din1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic          bram_we;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_din;
  logic [DW-1:0] bram_dout;
  logic          preload;

  always #5 clk = ~clk;

  bram_port_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .gnt0(gnt0), .gnt1(gnt1),
    .we0(we0), .we1(we1), .addr0(addr0), .addr1(addr1),
    .din0(din0), .din1(din1),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata0(rdata0), .rdata1(rdata1),
    .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
    .bram_dout(bram_dout)
  );

  // Behavioural single-port BRAM, read-first, one-cycle read latency.
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= DW'(i);
    end else begin
      if (bram_we) mem[bram_addr] <= bram_din;
      bram_dout <= mem[bram_addr];
    end
  end

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
  } op_t;

  typedef struct {
    int            id;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  op_t  ops0[$];
  op_t  ops1[$];
  exp_t sb[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model state: owner of the port in the current cycle (-1 = none),
  // last owner, and the BRAM command expected to be visible this cycle.
  int            owner = -1;
  int            last  = 1;
  logic          exp_we   = 1'b0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_din  = '0;
  logic [DW-1:0] ref_mem [256];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name, input string msg);
    checks++;
    failures++;
    $display("FAIL %s: %s (cycle %0d)", name, msg, cyc);
  endtask

  function automatic op_t mk(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    op_t o;
    o.we = we; o.addr = a; o.din = d;
    return o;
  endfunction

  // One cycle of the bench, called just after a falling edge.
  task automatic step();
    int  acc_id;
    op_t op;
    exp_t e;
    int  nxt;
    check("gnt0", gnt0, owner == 0);
    check("gnt1", gnt1, owner == 1);
    check("bram_we", bram_we, exp_we);
    check("bram_addr", bram_addr, exp_addr);
    check("bram_din", bram_din, exp_din);

    req0 = (ops0.size() > 0);
    req1 = (ops1.size() > 0);
    we0 = $urandom_range(0, 1); addr0 = AW'($urandom); din0 = $urandom;
    we1 = $urandom_range(0, 1); addr1 = AW'($urandom); din1 = $urandom;
    if (req0) begin we0 = ops0[0].we; addr0 = ops0[0].addr; din0 = ops0[0].din; end
    if (req1) begin we1 = ops1[0].we; addr1 = ops1[0].addr; din1 = ops1[0].din; end

    acc_id = -1;
    if (req0 && owner == 0) begin acc_id = 0; op = ops0.pop_front(); end
    if (req1 && owner == 1) begin acc_id = 1; op = ops1.pop_front(); end
    if (acc_id >= 0) begin
      if (op.we) ref_mem[op.addr] = op.din;
      else begin
        e.id = acc_id; e.data = ref_mem[op.addr]; e.due = cyc + 2;
        sb.push_back(e);
      end
      exp_we = op.we; exp_addr = op.addr; exp_din = op.din;
    end else begin
      exp_we = 1'b0;
    end

    if (owner == -1) begin
      if (req0 && req1) nxt = (last == 0) ? 1 : 0;
      else if (req0)    nxt = 0;
      else if (req1)    nxt = 1;
      else              nxt = -1;
    end else if ((owner == 0 && req0) || (owner == 1 && req1)) begin
      nxt = owner;
    end else begin
      last = owner;
      nxt = (owner == 0) ? (req1 ? 1 : -1) : (req0 ? 0 : -1);
    end
    owner = nxt;
  endtask

  task automatic run(input int n);
    repeat (n) begin @(negedge clk); step(); end
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while ((ops0.size() > 0 || ops1.size() > 0 || sb.size() > 0 || owner != -1) && n < bound) begin
      @(negedge clk); step(); n++;
    end
    if (ops0.size() > 0 || ops1.size() > 0 || sb.size() > 0 || owner != -1)
      flag("idle_timeout", "traffic did not drain within the cycle budget");
  endtask

  // Read monitor: every rvalid pops the oldest expected read.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rvalid0 || rvalid1) begin
        check("rv_exclusive", rvalid0 && rvalid1, 1'b0);
        if (sb.size() == 0) flag("rv_unexpected", "rvalid with no read outstanding");
        else begin
          e = sb.pop_front();
          check("rv_id", rvalid1 ? 1 : 0, e.id);
          check("rv_data", rvalid1 ? rdata1 : rdata0, e.data);
          check("rv_cycle", cyc, e.due);
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        flag("rv_missing", $sformatf("read for requester %0d due at cycle %0d never returned", e.id, e.due));
      end
    end
  end

  initial begin
    reset = 1'b1; preload = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; din0 = '0; din1 = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = DW'(i);
    repeat (2) @(posedge clk);
    @(negedge clk);
    preload = 1'b0;
    check("rst_gnt0", gnt0, 1'b0);
    check("rst_gnt1", gnt1, 1'b0);
    check("rst_bram_we", bram_we, 1'b0);
    check("rst_bram_addr", bram_addr, '0);
    check("rst_bram_din", bram_din, '0);
    check("rst_rvalid", {rvalid0, rvalid1}, 2'b00);
    reset = 1'b0;

    // Tie straight after reset: loader first, writer follows with no gap.
    ops0.push_back(mk(1'b0, 8'd3, '0)); ops0.push_back(mk(1'b0, 8'd4, '0));
    ops1.push_back(mk(1'b0, 8'd5, '0)); ops1.push_back(mk(1'b0, 8'd6, '0));
    wait_idle(40);

    // Single read burst of the flag word and the first image words.
    ops0.push_back(mk(1'b0, FLAG_ADDR, '0));
    ops0.push_back(mk(1'b0, IMG_BASE, '0));
    ops0.push_back(mk(1'b0, IMG_BASE + 8'd1, '0));
    ops0.push_back(mk(1'b0, IMG_BASE + 8'd2, '0));
    wait_idle(40);

    // Round-robin: writer burst alone, then a tie must go to the loader.
    ops1.push_back(mk(1'b0, 8'd20, '0));
    wait_idle(20);
    ops0.push_back(mk(1'b0, 8'd21, '0));
    ops1.push_back(mk(1'b0, 8'd22, '0));
    wait_idle(30);

    // Write result and flag, then read them back through the loader.
    ops1.push_back(mk(1'b1, RESULT_ADDR, 32'h0000_0007));
    wait_idle(20);
    ops1.push_back(mk(1'b1, FLAG_ADDR, FLAG_READY));
    wait_idle(20);
    ops0.push_back(mk(1'b0, RESULT_ADDR, '0));
    ops0.push_back(mk(1'b0, FLAG_ADDR, '0));
    wait_idle(30);

    // Reads in flight while ownership hands over to a waiting writer.
    ops0.push_back(mk(1'b0, 8'd10, '0)); ops0.push_back(mk(1'b0, 8'd11, '0));
    run(1);
    ops1.push_back(mk(1'b0, 8'd12, '0));
    wait_idle(30);

    // Asynchronous reset in the middle of a read burst.
    for (int i = 0; i < 8; i++) ops0.push_back(mk(1'b0, AW'(40 + i), '0));
    run(4);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_gnt0", gnt0, 1'b0);
    check("mid_rst_bram_we", bram_we, 1'b0);
    check("mid_rst_bram_addr", bram_addr, '0);
    check("mid_rst_rvalid", {rvalid0, rvalid1}, 2'b00);
    ops0.delete(); ops1.delete(); sb.delete();
    req0 = 0; req1 = 0;
    owner = -1; last = 1; exp_we = 1'b0; exp_addr = '0; exp_din = '0;
    run(2);
    reset = 1'b0;
    run(3);
    ops0.push_back(mk(1'b0, 8'd50, '0));
    wait_idle(30);

    // Randomized bursts from both requesters over a small address window.
    for (int c = 0; c < 400; c++) begin
      if (ops0.size() == 0 && $urandom_range(0, 5) == 0)
        for (int i = 0, n = $urandom_range(1, 5); i < n; i++)
          ops0.push_back(mk(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom));
      if (ops1.size() == 0 && $urandom_range(0, 5) == 0)
        for (int i = 0, n = $urandom_range(1, 5); i < n; i++)
          ops1.push_back(mk(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom));
      run(1);
    end
    wait_idle(80);
    run(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
